// File: rtl/timer_ctrl_pkg.sv
// Purpose: shared types and default sizes for the timer_ctrl sequencer.
// Contents: state_t (IDLE=0, RUN=1, DONE=2), default counter/run-count widths.
package timer_ctrl_pkg;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned REPEAT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_ctrl_counter_core.sv
// Purpose: free-running up-counter datapath driven by the timer_ctrl sequencer.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears count
//   en    - increment by one (wraps modulo 2^WIDTH)
//   clr   - synchronous clear, wins over en
//   count - current counter value
module counter_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Purpose: sequencer for counter_core. Accepts {limit, repeat} over valid/ready,
//   runs repeat periods of limit+1 cycles (repeat=0 runs until abort), pulses
//   tick at each terminal count and done one cycle after the last period.
// Optional: define TIMER_CTRL_PAUSE_EN to add a pause input that freezes a run.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   pause             - (TIMER_CTRL_PAUSE_EN only) hold count/runs while in RUN
//   cmd_valid/ready   - command handshake, ready only in IDLE
//   cmd_limit         - terminal count, period = limit+1 cycles
//   cmd_repeat        - number of periods, 0 = endless
//   abort             - end current run without done
//   count             - counter value
//   busy, tick, done  - RUN indicator, terminal-count strobe, completion pulse
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned REPEAT_W = REPEAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef TIMER_CTRL_PAUSE_EN
    input  logic                pause,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_limit,
    input  logic [REPEAT_W-1:0] cmd_repeat,
    input  logic                abort,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                tick,
    output logic                done
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic [REPEAT_W-1:0] runs_q, runs_d;
    logic                cnt_en, cnt_clr;
    logic                at_limit;
    logic                hold;

`ifdef TIMER_CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign at_limit = (count == limit_q);

    // Counter datapath
    counter_core #(
        .WIDTH (WIDTH)
    ) u_counter_core (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (count)
    );

    // State and command latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            runs_q  <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            runs_q  <= runs_d;
        end
    end

    // Next state, latch updates and counter control
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        runs_d  = runs_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (cmd_valid) begin
                    limit_d = cmd_limit;
                    runs_d  = cmd_repeat;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (hold) begin
                    cnt_en = 1'b0;
                end else if (at_limit) begin
                    cnt_clr = 1'b1;
                    // runs_q==0 is an endless run and is never decremented
                    if (runs_q == REPEAT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (runs_q != '0) begin
                        runs_d = runs_q - REPEAT_W'(1);
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign tick      = (state_q == ST_RUN) && at_limit && !hold;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencer for the free-running 4-bit counter datapath.
- Accepts a command (terminal value, run count) over a valid/ready handshake, runs the counter through the programmed number of wrap periods, then signals completion.
- Pulses `tick` at each terminal count. Sits between a host/config block and the counter.
- Counter becomes start/stop controllable, with programmable period and abort.

Parameters:
- WIDTH, 4, counter and limit width in bits
- REPEAT_W, 4, width of run-count field

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when both high at clk edge
- cmd_limit  input  WIDTH  terminal count; period = cmd_limit+1 cycles
- cmd_repeat  input  REPEAT_W  number of periods; 0 = endless until abort
- abort  input  1  stop current run, no done
- count  output  WIDTH  current counter value
- busy  output  1  high while in RUN
- tick  output  1  high during cycle where count==limit in RUN
- done  output  1  one-cycle pulse after last period completes

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst==0, asynchronous): state=IDLE, count=0, latched limit=0, runs_left=0. Outputs during and after reset: busy=0, tick=0, done=0, cmd_ready=1.
- Output decode:
  - cmd_ready = (state==IDLE)
  - busy = (state==RUN)
  - done = (state==DONE)
  - tick = (state==RUN && count==limit); combinational from registers only.
- IDLE: count held 0. On cmd_valid&&cmd_ready at edge: latch limit and runs_left=cmd_repeat, count<=0, state<=RUN. First RUN cycle shows count=0.
- RUN, per edge, priority order:
  1. abort: state<=IDLE, count<=0. No done. tick in that cycle still visible if count==limit.
  2. count==limit:
     - count<=0.
     - If runs_left==1: state<=DONE.
     - Else if runs_left!=0: runs_left<=runs_left-1.
     - runs_left==0 means endless: no decrement.
  3. Otherwise count<=count+1, modulo 2^WIDTH. Cannot exceed limit, since limit ≤ 2^WIDTH-1.
- DONE: lasts exactly one cycle, count=0, then state<=IDLE. cmd_ready=0 during DONE, so a new command is accepted no earlier than the cycle after done.
- Latency:
  - Accept → first tick = limit+1 cycles.
  - Last tick → done = 1 cycle.
  - Total accept → done = repeat*(limit+1)+1 cycles.
- limit=0: tick high every RUN cycle; count stays 0.
- cmd_valid while not IDLE: ignored; latched limit/runs_left unchanged.
- abort in IDLE or DONE: ignored. DONE still pulses and returns to IDLE.
- Reset mid-run: immediate IDLE, count=0, no done pulse on release.

Optional Feature:
- Macro: TIMER_CTRL_PAUSE_EN.
- Defined: adds input port `pause` (1 bit).
  - While pause=1 in RUN: count and runs_left hold, tick forced 0.
  - abort keeps priority over pause.
  - pause in IDLE/DONE has no effect.
- Undefined: no `pause` port; RUN always advances.

Decomposition:
- Package timer_ctrl_pkg:
  - state typedef, 2-bit encoding: IDLE=0, RUN=1, DONE=2.
  - default WIDTH/REPEAT_W constants.
- Sub-module counter_core:
  - Ports: clk, rst, en, clr, count.
  - Asynchronous active-low reset to 0; clr has priority over en; +1 when en.
- timer_ctrl holds the FSM, latches and terminal compare, and drives en/clr.

Test Plan:
1. rst=0 for 100 time units, clk period 10 → count=0, busy=0, tick=0, done=0, cmd_ready=1. After rst=1, count stays 0 in IDLE.
2. limit=3, repeat=2 → count sequence 0,1,2,3,0,1,2,3. tick in the 4th and 8th RUN cycles; done=1 in the 9th cycle after accept with busy=0; cmd_ready=1 the following cycle.
3. limit=0, repeat=3 → tick high 3 consecutive cycles, count always 0, done on the 4th cycle.
4. limit=15, repeat=0 → 15→0 wrap with tick every 16 cycles and no done over 100 cycles. Assert abort at count=7 → next cycle IDLE, count=0, no done.
5. During RUN (limit=5) drive cmd_valid with limit=2 → cmd_ready=0, period stays 6 cycles. With TIMER_CTRL_PAUSE_EN: pause 3 cycles at count=2 → count holds 2, completion delayed by 3 cycles.
6. rst pulsed low at count=2 of a run → count=0 and busy=0 asynchronously, no done after release.
